// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// Shares one sram_like slave port between an instruction-side and a data-side
// sram_like master. Only one transaction is in flight at a time. The data
// side normally wins a tie. A saturating starvation counter hands the next
// tie to the instruction side after STARVE_LIMIT consecutive data grants
// made while inst was waiting. STARVE_LIMIT = 0 gives strict data priority.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata_i     instruction master request bundle
//   inst_addr_ok_o, inst_data_ok_o    instruction master handshakes
//   inst_rdata_o                      instruction read data (valid with data_ok)
//   data_req/wr/size/addr/wdata_i     data master request bundle
//   data_addr_ok_o, data_data_ok_o    data master handshakes
//   data_rdata_o                      data read data (valid with data_ok)
//   slv_req/wr/size/addr/wdata_o      request bundle to the shared slave
//   slv_addr_ok_i, slv_data_ok_i      slave handshakes
//   slv_rdata_i                       slave read data
//   busy_o                            a transaction is owned (state != IDLE)
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              inst_req_i,
    input  logic              inst_wr_i,
    input  logic [1:0]        inst_size_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [DATA_W-1:0] inst_wdata_i,
    output logic              inst_addr_ok_o,
    output logic              inst_data_ok_o,
    output logic [DATA_W-1:0] inst_rdata_o,

    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_size_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_addr_ok_o,
    output logic              data_data_ok_o,
    output logic [DATA_W-1:0] data_rdata_o,

    output logic              slv_req_o,
    output logic              slv_wr_o,
    output logic [1:0]        slv_size_o,
    output logic [ADDR_W-1:0] slv_addr_o,
    output logic [DATA_W-1:0] slv_wdata_o,
    input  logic              slv_addr_ok_i,
    input  logic              slv_data_ok_i,
    input  logic [DATA_W-1:0] slv_rdata_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    state_t           state, state_next;
    owner_t           owner, owner_next;
    owner_t           sel;            // master whose bundle/handshakes are live this cycle
    logic [CNT_W-1:0] starve_cnt, starve_cnt_next;
    logic             cnt_at_limit;
    logic             inst_starved;
    logic             addr_ok_fwd;
    logic             data_ok_fwd;

    assign cnt_at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign inst_starved = (STARVE_LIMIT != 0) && cnt_at_limit;

    // Next-state, grant and handshake-forwarding logic.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so no
        // path can leave it unassigned and infer a latch.
        state_next      = state;
        owner_next      = owner;
        starve_cnt_next = starve_cnt;
        sel             = OWN_NONE;
        slv_req_o       = 1'b0;
        addr_ok_fwd     = 1'b0;
        data_ok_fwd     = 1'b0;

        // While reset is held every handshake and the slave request stay low.
        if (!rst_i) begin
            case (state)
                ST_IDLE: begin
                    if (inst_req_i && (!data_req_i || inst_starved)) begin
                        sel = OWN_INST;
                    end else if (data_req_i) begin
                        sel = OWN_DATA;
                    end

                    if (sel != OWN_NONE) begin
                        slv_req_o   = 1'b1;
                        addr_ok_fwd = slv_addr_ok_i;

                        // The counter only moves on a data grant that overtook a
                        // waiting inst request; saturates at STARVE_LIMIT.
                        if (sel == OWN_DATA && inst_req_i) begin
                            if (!cnt_at_limit) begin
                                starve_cnt_next = starve_cnt + 1'b1;
                            end
                        end else begin
                            starve_cnt_next = '0;
                        end

                        if (!slv_addr_ok_i) begin
                            state_next = ST_ADDR;
                            owner_next = sel;
                        end else if (!slv_data_ok_i) begin
                            state_next = ST_DATA;
                            owner_next = sel;
                        end else begin
                            // Zero-latency slave: complete without leaving IDLE.
                            data_ok_fwd = 1'b1;
                        end
                    end
                    // A data_ok with no grant is stray and ignored.
                end

                ST_ADDR: begin
                    sel       = owner;
                    slv_req_o = (owner == OWN_INST) ? inst_req_i :
                                (owner == OWN_DATA) ? data_req_i : 1'b0;
                    // data_ok before the address is accepted is stray and ignored.
                    if (slv_req_o && slv_addr_ok_i) begin
                        addr_ok_fwd = 1'b1;
                        if (slv_data_ok_i) begin
                            data_ok_fwd = 1'b1;
                            state_next  = ST_IDLE;
                            owner_next  = OWN_NONE;
                        end else begin
                            state_next  = ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    sel = owner;
                    if (slv_data_ok_i) begin
                        data_ok_fwd = 1'b1;
                        state_next  = ST_IDLE;
                        owner_next  = OWN_NONE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                    owner_next = OWN_NONE;
                end
            endcase
        end
    end

    // Slave request bundle follows the selected master.
    always_comb begin
        slv_wr_o    = 1'b0;
        slv_size_o  = '0;
        slv_addr_o  = '0;
        slv_wdata_o = '0;
        case (sel)
            OWN_INST: begin
                slv_wr_o    = inst_wr_i;
                slv_size_o  = inst_size_i;
                slv_addr_o  = inst_addr_i;
                slv_wdata_o = inst_wdata_i;
            end
            OWN_DATA: begin
                slv_wr_o    = data_wr_i;
                slv_size_o  = data_size_i;
                slv_addr_o  = data_addr_i;
                slv_wdata_o = data_wdata_i;
            end
            default: ;
        endcase
    end

    // Handshakes reach only the selected master; the other sees zeros.
    assign inst_addr_ok_o = addr_ok_fwd && (sel == OWN_INST);
    assign inst_data_ok_o = data_ok_fwd && (sel == OWN_INST);
    assign data_addr_ok_o = addr_ok_fwd && (sel == OWN_DATA);
    assign data_data_ok_o = data_ok_fwd && (sel == OWN_DATA);

    assign inst_rdata_o   = slv_rdata_i;
    assign data_rdata_o   = slv_rdata_i;

    assign busy_o         = !rst_i && (state != ST_IDLE);

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            starve_cnt <= starve_cnt_next;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter
//
// Self-checking bench for sram_like_arbiter: a cycle-by-cycle vector table,
// hand-written starvation and zero-latency sequences, then randomized
// traffic compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;
    localparam int CNT_W  = 3;
    localparam int N_RAND = 3000;

    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2000;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              inst_req_i, inst_wr_i;
    logic [1:0]        inst_size_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic [DATA_W-1:0] inst_wdata_i;
    logic              inst_addr_ok_o, inst_data_ok_o;
    logic [DATA_W-1:0] inst_rdata_o;
    logic              data_req_i, data_wr_i;
    logic [1:0]        data_size_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [DATA_W-1:0] data_wdata_i;
    logic              data_addr_ok_o, data_data_ok_o;
    logic [DATA_W-1:0] data_rdata_o;
    logic              slv_req_o, slv_wr_o;
    logic [1:0]        slv_size_o;
    logic [ADDR_W-1:0] slv_addr_o;
    logic [DATA_W-1:0] slv_wdata_o;
    logic              slv_addr_ok_i, slv_data_ok_i;
    logic [DATA_W-1:0] slv_rdata_i;
    logic              busy_o;

    always #5 clk = ~clk;

    sram_like_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .inst_req_i(inst_req_i), .inst_wr_i(inst_wr_i), .inst_size_i(inst_size_i),
        .inst_addr_i(inst_addr_i), .inst_wdata_i(inst_wdata_i),
        .inst_addr_ok_o(inst_addr_ok_o), .inst_data_ok_o(inst_data_ok_o),
        .inst_rdata_o(inst_rdata_o),
        .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_size_i(data_size_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_addr_ok_o(data_addr_ok_o), .data_data_ok_o(data_data_ok_o),
        .data_rdata_o(data_rdata_o),
        .slv_req_o(slv_req_o), .slv_wr_o(slv_wr_o), .slv_size_o(slv_size_o),
        .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o),
        .slv_addr_ok_i(slv_addr_ok_i), .slv_data_ok_i(slv_data_ok_i),
        .slv_rdata_i(slv_rdata_i),
        .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One row per clock: inputs for that cycle and the outputs required in it.
    typedef struct packed {
        logic        rst, ireq, dreq, aok, dok;
        logic        iaok, idok, daok, ddok, sreq, busy;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [0:19];

    // Transaction-level reference model state.
    int m_inflight[$];     // master id of the transaction in flight: 1 inst, 2 data
    bit m_addr_done;       // in-flight transaction's address already accepted
    int m_streak;          // consecutive data grants that overtook a waiting inst
    bit r_ireq, r_dreq;
    int who;
    bit presenting, e_aok, e_dok, e_busy, e_winner_inst;

    initial begin
        rst_i = 1'b1;
        inst_req_i = 1'b0; inst_wr_i = 1'b0; inst_size_i = 2'b10; inst_addr_i = IA; inst_wdata_i = '0;
        data_req_i = 1'b0; data_wr_i = 1'b0; data_size_i = 2'b10; data_addr_i = DA; data_wdata_i = '0;
        slv_addr_ok_i = 1'b0; slv_data_ok_i = 1'b0; slv_rdata_i = 32'hDEAD_BEEF;
        next_cycle();
        next_cycle();

        //           rst ireq dreq aok dok   iaok idok daok ddok sreq busy   addr
        vecs[0]  = {5'b1_1_1_1_1, 6'b0_0_0_0_0_0, 32'h0}; // outputs gated in reset
        vecs[1]  = {5'b0_1_0_1_0, 6'b1_0_0_0_1_0, IA};    // inst read, addr_ok at cycle 0
        vecs[2]  = {5'b0_0_0_0_0, 6'b0_0_0_0_0_1, 32'h0};
        vecs[3]  = {5'b0_0_0_0_1, 6'b0_1_0_0_0_1, 32'h0}; // data_ok at cycle 2
        vecs[4]  = {5'b0_1_1_1_0, 6'b0_0_1_0_1_0, DA};    // tie: data wins
        vecs[5]  = {5'b0_1_0_0_0, 6'b0_0_0_0_0_1, 32'h0}; // inst held off
        vecs[6]  = {5'b0_1_0_0_1, 6'b0_0_0_1_0_1, 32'h0};
        vecs[7]  = {5'b0_1_0_1_0, 6'b1_0_0_0_1_0, IA};    // inst right after
        vecs[8]  = {5'b0_0_0_0_1, 6'b0_1_0_0_0_1, 32'h0};
        vecs[9]  = {5'b0_0_1_0_0, 6'b0_0_0_0_1_0, DA};    // slave stalls addr_ok
        vecs[10] = {5'b0_1_1_0_0, 6'b0_0_0_0_1_1, DA};    // inst arrives, owner stays
        vecs[11] = {5'b0_1_1_0_0, 6'b0_0_0_0_1_1, DA};
        vecs[12] = {5'b0_1_1_1_0, 6'b0_0_1_0_1_1, DA};
        vecs[13] = {5'b0_1_0_0_1, 6'b0_0_0_1_0_1, 32'h0};
        vecs[14] = {5'b0_1_0_1_1, 6'b1_1_0_0_1_0, IA};    // zero-latency inst
        vecs[15] = {5'b0_0_0_0_1, 6'b0_0_0_0_0_0, 32'h0}; // stray data_ok in IDLE
        vecs[16] = {5'b0_0_1_1_0, 6'b0_0_1_0_1_0, DA};    // enter DATA
        vecs[17] = {5'b1_0_0_0_1, 6'b0_0_0_0_0_0, 32'h0}; // reset in DATA, no data_ok
        vecs[18] = {5'b0_0_0_0_1, 6'b0_0_0_0_0_0, 32'h0}; // stray data_ok after reset
        vecs[19] = {5'b0_0_0_0_0, 6'b0_0_0_0_0_0, 32'h0};

        for (int i = 0; i < 20; i++) begin
            rst_i = vecs[i].rst; inst_req_i = vecs[i].ireq; data_req_i = vecs[i].dreq;
            slv_addr_ok_i = vecs[i].aok; slv_data_ok_i = vecs[i].dok;
            #2;
            check($sformatf("v%0d_inst_addr_ok", i), inst_addr_ok_o, vecs[i].iaok);
            check($sformatf("v%0d_inst_data_ok", i), inst_data_ok_o, vecs[i].idok);
            check($sformatf("v%0d_data_addr_ok", i), data_addr_ok_o, vecs[i].daok);
            check($sformatf("v%0d_data_data_ok", i), data_data_ok_o, vecs[i].ddok);
            check($sformatf("v%0d_slv_req", i), slv_req_o, vecs[i].sreq);
            check($sformatf("v%0d_busy", i), busy_o, vecs[i].busy);
            if (vecs[i].sreq) check($sformatf("v%0d_slv_addr", i), slv_addr_o, vecs[i].addr);
            if (vecs[i].idok) check($sformatf("v%0d_inst_rdata", i), inst_rdata_o, 32'hDEAD_BEEF);
            if (vecs[i].ddok) check($sformatf("v%0d_data_rdata", i), data_rdata_o, 32'hDEAD_BEEF);
            next_cycle();
        end

        // Starvation: both held high; four data grants, inst on the fifth,
        // then the counter is clear again so data wins the sixth.
        rst_i = 1'b0; inst_req_i = 1'b1; data_req_i = 1'b1;
        for (int g = 0; g < 6; g++) begin
            slv_addr_ok_i = 1'b1; slv_data_ok_i = 1'b0;
            #2;
            check($sformatf("starve%0d_inst_addr_ok", g), inst_addr_ok_o, (g == 4));
            check($sformatf("starve%0d_data_addr_ok", g), data_addr_ok_o, (g != 4));
            check($sformatf("starve%0d_slv_addr", g), slv_addr_o, (g == 4) ? IA : DA);
            next_cycle();
            slv_addr_ok_i = 1'b0; slv_data_ok_i = 1'b1;
            #2;
            check($sformatf("starve%0d_inst_data_ok", g), inst_data_ok_o, (g == 4));
            check($sformatf("starve%0d_data_data_ok", g), data_data_ok_o, (g != 4));
            next_cycle();
        end

        // Zero-latency data write of size 2'b10.
        inst_req_i = 1'b0; data_req_i = 1'b1; data_wr_i = 1'b1; data_size_i = 2'b10;
        data_wdata_i = 32'h1234_5678; slv_addr_ok_i = 1'b1; slv_data_ok_i = 1'b1;
        #2;
        check("zl_data_addr_ok", data_addr_ok_o, 1'b1);
        check("zl_data_data_ok", data_data_ok_o, 1'b1);
        check("zl_inst_data_ok", inst_data_ok_o, 1'b0);
        check("zl_slv_wr", slv_wr_o, 1'b1);
        check("zl_slv_size", slv_size_o, 2'b10);
        check("zl_slv_wdata", slv_wdata_o, 32'h1234_5678);
        check("zl_slv_addr", slv_addr_o, DA);
        next_cycle();
        data_req_i = 1'b0; data_wr_i = 1'b0; slv_addr_ok_i = 1'b0; slv_data_ok_i = 1'b0;
        #2;
        check("zl_busy_after", busy_o, 1'b0);
        next_cycle();

        // Randomized traffic against the reference model.
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        m_inflight.delete(); m_addr_done = 1'b0; m_streak = 0;
        r_ireq = 1'b0; r_dreq = 1'b0;
        for (int c = 0; c < N_RAND; c++) begin
            // Masters: raise a fresh request at random, hold it until addr_ok.
            if (!r_ireq && ($urandom_range(1, 0) == 1)) begin
                r_ireq = 1'b1;
                inst_wr_i = 1'($urandom_range(1, 0)); inst_size_i = 2'($urandom_range(2, 0));
                inst_addr_i = $urandom; inst_wdata_i = $urandom;
            end
            if (!r_dreq && ($urandom_range(1, 0) == 1)) begin
                r_dreq = 1'b1;
                data_wr_i = 1'($urandom_range(1, 0)); data_size_i = 2'($urandom_range(2, 0));
                data_addr_i = $urandom; data_wdata_i = $urandom;
            end
            inst_req_i = r_ireq; data_req_i = r_dreq;
            slv_addr_ok_i = 1'($urandom_range(1, 0));
            slv_data_ok_i = ($urandom_range(2, 0) == 0);
            slv_rdata_i   = $urandom;
            #2;

            e_busy = (m_inflight.size() != 0);
            e_aok = 1'b0; e_dok = 1'b0;
            if (m_inflight.size() == 0) begin
                if (inst_req_i && data_req_i) who = (LIMIT != 0 && m_streak >= LIMIT) ? 1 : 2;
                else if (inst_req_i) who = 1;
                else if (data_req_i) who = 2;
                else who = 0;
                presenting = (who != 0);
                e_aok = presenting && slv_addr_ok_i;
                e_dok = e_aok && slv_data_ok_i;
            end else begin
                who = m_inflight[0];
                if (!m_addr_done) begin
                    presenting = (who == 1) ? inst_req_i : data_req_i;
                    e_aok = presenting && slv_addr_ok_i;
                    e_dok = e_aok && slv_data_ok_i;
                end else begin
                    presenting = 1'b0;
                    e_dok = slv_data_ok_i;
                end
            end
            e_winner_inst = (who == 1);

            check($sformatf("r%0d_busy", c), busy_o, e_busy);
            check($sformatf("r%0d_slv_req", c), slv_req_o, presenting);
            check($sformatf("r%0d_inst_addr_ok", c), inst_addr_ok_o, e_aok && e_winner_inst);
            check($sformatf("r%0d_data_addr_ok", c), data_addr_ok_o, e_aok && (who == 2));
            check($sformatf("r%0d_inst_data_ok", c), inst_data_ok_o, e_dok && e_winner_inst);
            check($sformatf("r%0d_data_data_ok", c), data_data_ok_o, e_dok && (who == 2));
            if (presenting) begin
                check($sformatf("r%0d_slv_addr", c), slv_addr_o, e_winner_inst ? inst_addr_i : data_addr_i);
                check($sformatf("r%0d_slv_wdata", c), slv_wdata_o, e_winner_inst ? inst_wdata_i : data_wdata_i);
                check($sformatf("r%0d_slv_wr", c), slv_wr_o, e_winner_inst ? inst_wr_i : data_wr_i);
                check($sformatf("r%0d_slv_size", c), slv_size_o, e_winner_inst ? inst_size_i : data_size_i);
            end
            if (e_dok && e_winner_inst) check($sformatf("r%0d_inst_rdata", c), inst_rdata_o, slv_rdata_i);
            if (e_dok && (who == 2)) check($sformatf("r%0d_data_rdata", c), data_rdata_o, slv_rdata_i);

            // Advance the model by one clock.
            if (m_inflight.size() == 0) begin
                if (who != 0) begin
                    if (who == 2 && inst_req_i) m_streak = (m_streak < LIMIT) ? m_streak + 1 : m_streak;
                    else m_streak = 0;
                    if (!e_dok) begin
                        m_inflight.push_back(who);
                        m_addr_done = e_aok;
                    end
                end
            end else if (e_dok) begin
                void'(m_inflight.pop_front());
                m_addr_done = 1'b0;
            end else if (e_aok) begin
                m_addr_done = 1'b1;
            end
            if (e_aok && e_winner_inst) r_ireq = 1'b0;
            if (e_aok && (who == 2)) r_dreq = 1'b0;
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
